// File: rtl/match_seq_ctrl_pkg.sv
// Shared types and defaults for the match job sequencer: FSM states, error codes,
// default loop lengths.
package match_seq_ctrl_pkg;

    localparam int DEF_IMG_VEC_N = 4;
    localparam int DEF_LIB_VEC_N = 8;

    // A healthy row needs LIB_VEC_N ready cycles; twice that means the generator is stuck.
    function automatic int wdog_cyc(input int lib_n);
        return 2 * lib_n;
    endfunction

    localparam int DEF_WDOG_CYC = wdog_cyc(DEF_LIB_VEC_N);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FIRE = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_ROWCNT  = 2'd2,
        ERR_ABORT   = 2'd3
    } err_t;

endpackage

// File: rtl/match_seq_ctrl_if.sv
// Sequencer <-> address generator handshake bundle.
interface match_seq_ctrl_if;
    logic gen_fire;
    logic gen_ready;
    logic gen_clr;
    logic gen_linefeed;
    logic gen_finish;

    modport master (
        output gen_fire,
        output gen_ready,
        output gen_clr,
        input  gen_linefeed,
        input  gen_finish
    );

    modport slave (
        input  gen_fire,
        input  gen_ready,
        input  gen_clr,
        output gen_linefeed,
        output gen_finish
    );
endinterface

// File: rtl/match_seq_wdog.sv
// Load/clear/enable watchdog counter; o_expire flags the enabled cycle whose
// increment reaches LIMIT, so the owner can react on that same edge.
module match_seq_wdog #(
    parameter  int LIMIT = 16,
    localparam int CW    = $clog2(LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    output logic          o_expire
);

    logic [CW-1:0] r_cnt;

    assign o_expire = i_en && (r_cnt >= CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != CW'(LIMIT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/match_seq_ctrl.sv
// Job-level sequencer: start -> fire pulse -> ready-gated run with row counting and
// stall watchdog -> done/irq or error. Optional MATCH_SEQ_CTRL_PERF_EN adds cycle counters.
module match_seq_ctrl
    import match_seq_ctrl_pkg::*;
#(
    parameter  int IMG_VEC_N = DEF_IMG_VEC_N,
    parameter  int LIB_VEC_N = DEF_LIB_VEC_N,
    parameter  int WDOG_CYC  = wdog_cyc(LIB_VEC_N),
    localparam int LCW       = $clog2(IMG_VEC_N + 1),
    localparam int LSW       = LCW + 1,
    localparam int WCW       = $clog2(WDOG_CYC + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_irq_clr,
    input  logic                  i_dn_ready,
    match_seq_ctrl_if.master      gen_if,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_irq,
    output logic [1:0]            o_err,
    output logic [LCW-1:0]        o_line_cnt
`ifdef MATCH_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]           o_run_cycles,
    output logic [31:0]           o_stall_cycles
`endif
);

    state_t         r_state;
    state_t         w_state_next;
    err_t           r_err;
    err_t           w_err_next;
    logic           w_irq_next;
    logic           w_start_acc;
    logic           w_in_run;
    logic           w_wdog_en;
    logic           w_wdog_clr;
    logic           w_wdog_expire;
    logic [LSW-1:0] w_line_sum;
    logic [LCW-1:0] r_line_cnt;
    logic           r_gen_fire;
    logic           r_gen_clr;
    logic           r_busy;
    logic           r_done;
    logic           r_irq;

    assign w_in_run   = (r_state == S_RUN);
    assign w_line_sum = {1'b0, r_line_cnt} + LSW'(gen_if.gen_linefeed);
    assign w_wdog_en  = w_in_run && i_dn_ready && !gen_if.gen_linefeed;
    assign w_wdog_clr = w_start_acc || (w_in_run && gen_if.gen_linefeed);

    match_seq_wdog #(
        .LIMIT (WDOG_CYC)
    ) u_wdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_wdog_clr),
        .i_load     (1'b0),
        .i_load_val ({WCW{1'b0}}),
        .i_en       (w_wdog_en),
        .o_expire   (w_wdog_expire)
    );

    // Event priority inside RUN: finish, then abort, then watchdog expiry.
    always_comb begin
        w_state_next = r_state;
        w_err_next   = i_irq_clr ? ERR_NONE : r_err;
        w_start_acc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_FIRE;
                    w_start_acc  = 1'b1;
                    w_err_next   = ERR_NONE;
                end
            end
            S_FIRE: begin
                if (i_abort) begin
                    w_state_next = S_ERR;
                    w_err_next   = ERR_ABORT;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (gen_if.gen_finish) begin
                    if (w_line_sum == LSW'(IMG_VEC_N)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_ERR;
                        w_err_next   = ERR_ROWCNT;
                    end
                end else if (i_abort) begin
                    w_state_next = S_ERR;
                    w_err_next   = ERR_ABORT;
                end else if (w_wdog_expire) begin
                    w_state_next = S_ERR;
                    w_err_next   = ERR_TIMEOUT;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        // Completion or error sets irq on the edge it is reported; set beats irq_clr.
        if ((w_state_next == S_DONE) || (w_state_next == S_ERR)) begin
            w_irq_next = 1'b1;
        end else begin
            w_irq_next = i_irq_clr ? 1'b0 : r_irq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_err      <= ERR_NONE;
            r_irq      <= 1'b0;
            r_gen_fire <= 1'b0;
            r_gen_clr  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_line_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_err      <= w_err_next;
            r_irq      <= w_irq_next;
            r_gen_fire <= (w_state_next == S_FIRE);
            r_gen_clr  <= (w_state_next == S_ERR);
            r_busy     <= (w_state_next == S_FIRE) || (w_state_next == S_RUN);
            r_done     <= (w_state_next == S_DONE);
            if (w_start_acc) begin
                r_line_cnt <= '0;
            end else if (w_in_run && gen_if.gen_linefeed && (r_line_cnt != LCW'(IMG_VEC_N))) begin
                r_line_cnt <= r_line_cnt + 1'b1;
            end
        end
    end

`ifdef MATCH_SEQ_CTRL_PERF_EN
    logic [31:0] r_run_cycles;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cycles   <= '0;
            r_stall_cycles <= '0;
        end else if (w_start_acc) begin
            r_run_cycles   <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (((r_state == S_FIRE) || w_in_run) && (r_run_cycles != '1)) begin
                r_run_cycles <= r_run_cycles + 32'd1;
            end
            if (w_in_run && !i_dn_ready && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign o_run_cycles   = r_run_cycles;
    assign o_stall_cycles = r_stall_cycles;
`endif

    // gen_ready is the only combinational output: downstream ready passes straight through in RUN.
    assign gen_if.gen_ready = w_in_run && i_dn_ready;
    assign gen_if.gen_fire  = r_gen_fire;
    assign gen_if.gen_clr   = r_gen_clr;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_irq            = r_irq;
    assign o_err            = r_err;
    assign o_line_cnt       = r_line_cnt;

endmodule

// File: tb/tb_match_seq_ctrl.sv
// Directed bench for match_seq_ctrl with IMG_VEC_N=4, LIB_VEC_N=8 (watchdog 16).
module tb_match_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       irq_clr;
    logic       dn_ready;
    logic       busy;
    logic       done;
    logic       irq;
    logic [1:0] err;
    logic [2:0] line_cnt;
`ifdef MATCH_SEQ_CTRL_PERF_EN
    logic [31:0] run_cycles;
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    match_seq_ctrl_if gen_if();

    match_seq_ctrl #(
        .IMG_VEC_N (4),
        .LIB_VEC_N (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (start),
        .i_abort    (abort),
        .i_irq_clr  (irq_clr),
        .i_dn_ready (dn_ready),
        .gen_if     (gen_if.master),
        .o_busy     (busy),
        .o_done     (done),
        .o_irq      (irq),
        .o_err      (err),
        .o_line_cnt (line_cnt)
`ifdef MATCH_SEQ_CTRL_PERF_EN
        ,
        .o_run_cycles   (run_cycles),
        .o_stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 2 time units after each rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic linefeeds(input int n);
        for (int i = 0; i < n; i++) begin
            gen_if.gen_linefeed = 1'b1;
            tick();
            gen_if.gen_linefeed = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        dn_ready = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b expected 0", irq); end
        checks++; if (err !== 2'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err); end
        checks++; if (line_cnt !== 3'd0) begin errors++; $display("FAIL reset_line_cnt: got %0d expected 0", line_cnt); end
        checks++; if (gen_if.gen_fire !== 1'b0 || gen_if.gen_clr !== 1'b0 || gen_if.gen_ready !== 1'b0) begin
            errors++; $display("FAIL reset_gen: got fire=%0b clr=%0b ready=%0b expected 0 0 0",
                               gen_if.gen_fire, gen_if.gen_clr, gen_if.gen_ready);
        end
        rst_n = 1'b1;
        tick();
        $display("txn reset: busy=%0b irq=%0b err=%0d", busy, irq, err);
    endtask

    task automatic test_normal();
        dn_ready = 1'b1;
        #1;
        checks++; if (gen_if.gen_ready !== 1'b0) begin errors++; $display("FAIL normal_ready_idle: got %0b expected 0", gen_if.gen_ready); end
        pulse_start();
        checks++; if (gen_if.gen_fire !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL normal_fire: got fire=%0b busy=%0b expected 1 1", gen_if.gen_fire, busy);
        end
        tick();
        checks++; if (gen_if.gen_fire !== 1'b0 || gen_if.gen_ready !== 1'b1) begin
            errors++; $display("FAIL normal_run_entry: got fire=%0b ready=%0b expected 0 1", gen_if.gen_fire, gen_if.gen_ready);
        end
        linefeeds(4);
        checks++; if (line_cnt !== 3'd4) begin errors++; $display("FAIL normal_line_cnt_run: got %0d expected 4", line_cnt); end
        gen_if.gen_finish = 1'b1;
        tick();
        gen_if.gen_finish = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || irq !== 1'b1 || err !== 2'd0 || line_cnt !== 3'd4) begin
            errors++; $display("FAIL normal_done: got done=%0b busy=%0b irq=%0b err=%0d lc=%0d expected 1 0 1 0 4",
                               done, busy, irq, err, line_cnt);
        end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL normal_done_pulse: got %0b expected 0", done); end
        $display("txn normal: line_cnt=%0d irq=%0b err=%0d", line_cnt, irq, err);
    endtask

    task automatic test_ready_toggle();
        int stalls;
        stalls = 0;
        pulse_start();
        dn_ready = 1'b1;
        #1;
        checks++; if (gen_if.gen_ready !== 1'b0) begin errors++; $display("FAIL toggle_ready_fire: got %0b expected 0", gen_if.gen_ready); end
        tick();
        for (int i = 0; i < 16; i++) begin
            dn_ready            = ((i % 2) == 0);
            gen_if.gen_linefeed = ((i % 4) == 2);
            if (!dn_ready) stalls++;
            #1;
            checks++; if (gen_if.gen_ready !== dn_ready) begin
                errors++; $display("FAIL toggle_ready_run%0d: got %0b expected %0b", i, gen_if.gen_ready, dn_ready);
            end
            tick();
        end
        gen_if.gen_linefeed = 1'b0;
        dn_ready = 1'b1;
        gen_if.gen_finish = 1'b1;
        tick();
        gen_if.gen_finish = 1'b0;
        checks++; if (done !== 1'b1 || err !== 2'd0 || line_cnt !== 3'd4) begin
            errors++; $display("FAIL toggle_done: got done=%0b err=%0d lc=%0d expected 1 0 4", done, err, line_cnt);
        end
`ifdef MATCH_SEQ_CTRL_PERF_EN
        checks++; if (stall_cycles !== 32'(stalls)) begin
            errors++; $display("FAIL toggle_stall_cycles: got %0d expected %0d", stall_cycles, stalls);
        end
        checks++; if (run_cycles !== 32'd18) begin
            errors++; $display("FAIL toggle_run_cycles: got %0d expected 18", run_cycles);
        end
`endif
        tick();
        $display("txn ready_toggle: stalls=%0d line_cnt=%0d", stalls, line_cnt);
    endtask

    task automatic test_irq_clr();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        checks++; if (irq !== 1'b0 || err !== 2'd0) begin
            errors++; $display("FAIL irq_clr: got irq=%0b err=%0d expected 0 0", irq, err);
        end
        $display("txn irq_clr: irq=%0b err=%0d", irq, err);
    endtask

    task automatic test_timeout();
        dn_ready = 1'b1;
        pulse_start();
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                checks++; if (busy !== 1'b1 || err !== 2'd0) begin
                    errors++; $display("FAIL timeout_early: got busy=%0b err=%0d expected 1 0", busy, err);
                end
            end
            tick();
        end
        checks++; if (err !== 2'd1 || gen_if.gen_clr !== 1'b1 || irq !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_err: got err=%0d clr=%0b irq=%0b busy=%0b expected 1 1 1 0",
                               err, gen_if.gen_clr, irq, busy);
        end
        tick();
        checks++; if (gen_if.gen_clr !== 1'b0 || err !== 2'd1) begin
            errors++; $display("FAIL timeout_hold: got clr=%0b err=%0d expected 0 1", gen_if.gen_clr, err);
        end
        $display("txn timeout: err=%0d irq=%0b", err, irq);
    endtask

    task automatic test_abort();
        dn_ready = 1'b1;
        pulse_start();
        tick();
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (err !== 2'd3 || gen_if.gen_clr !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_err: got err=%0d clr=%0b busy=%0b expected 3 1 0", err, gen_if.gen_clr, busy);
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || err !== 2'd3 || gen_if.gen_clr !== 1'b0) begin
            errors++; $display("FAIL abort_idle_ignored: got busy=%0b err=%0d clr=%0b expected 0 3 0", busy, err, gen_if.gen_clr);
        end
        pulse_start();
        checks++; if (err !== 2'd0) begin errors++; $display("FAIL abort_start_clears_err: got %0d expected 0", err); end
        tick();
        linefeeds(4);
        gen_if.gen_finish = 1'b1;
        abort = 1'b1;
        tick();
        gen_if.gen_finish = 1'b0;
        abort = 1'b0;
        checks++; if (done !== 1'b1 || err !== 2'd0) begin
            errors++; $display("FAIL abort_with_finish: got done=%0b err=%0d expected 1 0", done, err);
        end
        tick();
        $display("txn abort: err=%0d", err);
    endtask

    task automatic test_rowcnt();
        pulse_start();
        tick();
        linefeeds(3);
        gen_if.gen_finish = 1'b1;
        tick();
        gen_if.gen_finish = 1'b0;
        checks++; if (err !== 2'd2 || done !== 1'b0 || line_cnt !== 3'd3) begin
            errors++; $display("FAIL rowcnt: got err=%0d done=%0b lc=%0d expected 2 0 3", err, done, line_cnt);
        end
        tick();
        $display("txn rowcnt: err=%0d line_cnt=%0d", err, line_cnt);
    endtask

    task automatic test_back_to_back();
        pulse_start();
        tick();
        linefeeds(2);
        pulse_start();
        checks++; if (gen_if.gen_fire !== 1'b0 || busy !== 1'b1 || line_cnt !== 3'd2) begin
            errors++; $display("FAIL start_busy_ignored: got fire=%0b busy=%0b lc=%0d expected 0 1 2",
                               gen_if.gen_fire, busy, line_cnt);
        end
        linefeeds(2);
        gen_if.gen_finish = 1'b1;
        tick();
        gen_if.gen_finish = 1'b0;
        start = 1'b1;
        tick();
        checks++; if (gen_if.gen_fire !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL start_in_done_ignored: got fire=%0b busy=%0b expected 0 0", gen_if.gen_fire, busy);
        end
        tick();
        start = 1'b0;
        checks++; if (gen_if.gen_fire !== 1'b1 || line_cnt !== 3'd0) begin
            errors++; $display("FAIL back_to_back_fire: got fire=%0b lc=%0d expected 1 0", gen_if.gen_fire, line_cnt);
        end
        $display("txn back_to_back: fire=%0b busy=%0b", gen_if.gen_fire, busy);
    endtask

    task automatic test_reset_midrun();
        dn_ready = 1'b1;
        tick();
        linefeeds(1);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || gen_if.gen_ready !== 1'b0 || line_cnt !== 3'd0 || irq !== 1'b0 ||
                      err !== 2'd0 || done !== 1'b0 || gen_if.gen_fire !== 1'b0 || gen_if.gen_clr !== 1'b0) begin
            errors++; $display("FAIL reset_midrun: got busy=%0b ready=%0b lc=%0d irq=%0b err=%0d expected all 0",
                               busy, gen_if.gen_ready, line_cnt, irq, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("txn reset_midrun: busy=%0b line_cnt=%0d", busy, line_cnt);
    endtask

    initial begin
        rst_n               = 1'b0;
        start               = 1'b0;
        abort               = 1'b0;
        irq_clr             = 1'b0;
        dn_ready            = 1'b0;
        gen_if.gen_linefeed = 1'b0;
        gen_if.gen_finish   = 1'b0;
        test_reset();
        test_normal();
        test_ready_toggle();
        test_irq_clr();
        test_timeout();
        test_irq_clr();
        test_abort();
        test_rowcnt();
        test_back_to_back();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/match_seq_ctrl.md
# match_seq_ctrl

Job-level sequencer for the star-library / image-vector address generator. It accepts a host start command and issues the single-cycle fire pulse. It then gates generator progress with downstream ready, counts completed image rows via linefeed, and watches for stalls. It closes the job with done/irq or an error code, and sits between the PS-side control registers and the address generator feeding the match datapath.

## Interface
Parameters:
- IMG_VEC_N, `CFG_IMG_VEC_NUM, image vectors per job (outer loop length)
- LIB_VEC_N, `CFG_LIB_VEC_NUM, library vectors per row (inner loop length)
- WDOG_CYC, 2*LIB_VEC_N, max gen_ready-high cycles allowed between two linefeeds

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  host start pulse; honoured only in IDLE
- abort  in  1  host abort pulse; honoured in FIRE/RUN
- irq_clr  in  1  clears irq and err
- dn_ready  in  1  downstream ready from match datapath
- gen_fire  out  1  fire pulse to address generator
- gen_ready  out  1  next_ready to address generator
- gen_clr  out  1  one-cycle soft clear to generator (integration ORs into its reset)
- gen_linefeed  in  1  row-complete pulse from generator
- gen_finish  in  1  job-complete pulse from generator
- busy  out  1  high in FIRE/RUN
- done  out  1  one-cycle pulse on successful completion
- irq  out  1  sticky; set on done or error
- err  out  2  0 none, 1 timeout, 2 row-count mismatch, 3 aborted
- line_cnt  out  clog2(IMG_VEC_N+1)  rows completed in current/last job

## Operation
- States: IDLE, FIRE, RUN, DONE, ERR.
- IDLE: start → FIRE; line_cnt and watchdog cleared on the same edge.
- FIRE: gen_fire=1 for exactly this one cycle → RUN.
- RUN: gen_ready=dn_ready. Each gen_linefeed increments line_cnt, saturating at IMG_VEC_N.
- RUN, gen_finish: if line_cnt+linefeed equals IMG_VEC_N → DONE; otherwise err=2 → ERR.
- DONE: done=1 for one cycle, irq set → IDLE.
- ERR: gen_clr=1 for one cycle, irq set → IDLE; err holds until irq_clr or the next start.
- Watchdog: increments on RUN cycles with gen_ready=1 and no linefeed, and clears on linefeed. Reaching WDOG_CYC in RUN → err=1, ERR.
- abort in FIRE/RUN → err=3, ERR. abort in IDLE/DONE/ERR is ignored.
- start outside IDLE is ignored; no queueing.
- Simultaneous events:
  - gen_finish with abort: finish wins.
  - gen_finish with watchdog expiry: finish wins.
  - irq_clr with an irq set: set wins.
- gen_ready=0 in all states except RUN.

## Timing
- Reset values:
  - state=IDLE.
  - gen_fire, gen_clr, busy, done, irq = 0.
  - gen_ready=0, err=0, line_cnt=0.
- start (cycle t) → gen_fire high at t+1 → RUN from t+2. All outputs are registered.
- gen_finish at t → done at t+1 → busy low at t+1 → IDLE at t+2; a new start is accepted at t+2.
- gen_ready is combinational from dn_ready while in RUN; this is the only combinational path.
- Reset mid-job returns to IDLE immediately. The generator shares rst_n and also resets.

## Configuration
- MATCH_SEQ_CTRL_PERF_EN defined:
  - Adds output run_cycles (32 bit), counting cycles spent in FIRE/RUN, saturating at all-ones.
  - Adds output stall_cycles (32 bit), counting RUN cycles with dn_ready=0.
  - Both clear on accepted start and hold after job end.
- MATCH_SEQ_CTRL_PERF_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package/header (config.vh): state encoding constants, err code constants (ERR_NONE/TIMEOUT/ROWCNT/ABORT), and default WDOG_CYC.
- One sub-module: match_seq_wdog (load/clear/enable counter with expiry flag), reused by later per-stage watchdogs.

## Test plan
- IMG_VEC_N=4, LIB_VEC_N=8, dn_ready=1, start → gen_fire for one cycle, 4 linefeeds, finish, done pulse, irq=1, err=0, line_cnt=4.
- dn_ready toggled 50% → gen_ready follows only in RUN, no timeout, job completes with line_cnt=4. With PERF_EN, stall_cycles equals the count of low-ready RUN cycles.
- Generator model stops emitting linefeed → after 16 ready cycles err=1, gen_clr pulse, irq=1, busy=0.
- abort 5 cycles into RUN → err=3, ERR then IDLE; abort together with finish → done, err=0.
- Finish after only 3 linefeeds → err=2.
- start while busy → ignored.
- irq_clr → irq=0, err=0.
- rst_n low mid-RUN → all outputs at reset values within the same cycle.
